// File: rtl/serial_alu.sv
// serial_alu: bit-serial LSB-first ALU stage with a single carry flop and flags latched on completion.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       carry_in,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       shift_en,
  output logic       result_bit,
  output logic       result_we,
  output logic       busy,
  output logic       done,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] bit_cnt;
  logic [2:0] op_r;
  logic carry, zacc, is_sub, arith, last, b_eff, sum, c_next, logic_bit;
  assign is_sub    = op_r == 3'd1 || op_r == 3'd7;
  assign arith     = op_r == 3'd0 || is_sub || op_r == 3'd6;
  assign last      = bit_cnt == CW'(WIDTH - 1);
  assign b_eff     = is_sub ? ~b_bit : b_bit;
  assign sum       = a_bit ^ b_eff ^ carry;
  assign c_next    = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
  assign logic_bit = op_r == 3'd2 ? a_bit & b_bit :
                     op_r == 3'd3 ? a_bit | b_bit :
                     op_r == 3'd4 ? a_bit ^ b_bit : b_bit;
  assign shift_en   = state == RUN;
  assign result_we  = shift_en && op_r != 3'd7;
  assign result_bit = shift_en && (arith ? sum : logic_bit);
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      op_r    <= 3'd0;
      carry   <= 1'b0;
      zacc    <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        op_r  <= op;
        carry <= (op == 3'd1 || op == 3'd7) ? 1'b1 : op == 3'd6 ? carry_in : 1'b0;
        zacc  <= 1'b1;
      end
      if (state == RUN) begin
        carry   <= c_next;
        zacc    <= zacc & ~result_bit;
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
        if (last) begin
          flag_z <= zacc & ~result_bit;
          flag_n <= result_bit;
          flag_c <= arith & c_next;
          flag_v <= arith & (carry ^ c_next);
        end
      end
    end
  end
endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial ALU stage for the bit-serial CPU datapath. On a start pulse it runs exactly WIDTH cycles. Each cycle it consumes one LSB-first bit of each operand from the upstream operand shift registers and produces one result bit on `result_bit`. That bit drives `serial_in` of the downstream destination shift register, and `shift_en` drives that register's `en`. Carry is held in a single flip-flop across bits. Flags are published with a one-cycle done pulse.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
- op  input  3  opcode, captured on accepted start: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASSB, 6 ADC, 7 CMP.
- carry_in  input  1  carry seed for ADC, captured on accepted start.
- a_bit  input  1  current operand-A bit, LSB first.
- b_bit  input  1  current operand-B bit, LSB first.
- shift_en  output  1  high during every RUN cycle; advances operand and destination registers.
- result_bit  output  1  combinational result bit for the current cycle; 0 outside RUN.
- result_we  output  1  high with shift_en, except for CMP, where it is 0.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- flag_c, flag_z, flag_n, flag_v  output  1 each  carry, zero, negative, signed overflow of the last completed operation.

## Operation

- States:
  - IDLE: start=1 captures op and initialises the carry flip-flop, then moves to RUN.
  - RUN: lasts WIDTH cycles, counted by bit_cnt 0..WIDTH-1; moves to DONE after bit_cnt==WIDTH-1.
  - DONE: lasts one cycle, then returns to IDLE.
- Carry initialisation on accepted start:
  - ADD: 0.
  - SUB and CMP: 1.
  - ADC: carry_in.
  - Logic ops: 0, unused.
- Effective B:
  - SUB and CMP: ~b_bit.
  - All other ops: b_bit.
- Per-bit result:
  - Arithmetic ops: sum = a ^ b_eff ^ c, and c_next = majority(a, b_eff, c).
  - AND/OR/XOR: bitwise combination of a_bit and b_bit.
  - PASSB: b_bit.
- The carry flip-flop updates only in RUN.
- Zero accumulator:
  - Set to 1 on start.
  - ANDed with ~result_bit every RUN cycle.
- At the RUN→DONE edge the flag registers load as follows:
  - flag_z: the accumulator value including the MSB bit.
  - flag_n: the MSB result bit.
  - flag_c: final carry out for arithmetic ops; 1 means no borrow for SUB/CMP. Cleared to 0 for logic ops.
  - flag_v: carry into MSB XOR carry out of MSB for arithmetic ops; 0 for logic ops.
- Flags hold their value until the next completed operation. They do not change at start.
- CMP computes and flags exactly as SUB, but result_we stays 0. The destination register is not written; shift_en still pulses so the operands rotate.
- start is ignored while busy. op and carry_in changes during RUN have no effect.
- Reset (asynchronous, any time including mid-RUN) clears everything:
  - State returns to IDLE and bit_cnt to 0.
  - carry is cleared to 0.
  - All flags are 0.
  - shift_en, result_we, result_bit, busy and done are all 0.
  - A partially written destination is not repaired; the controller must reissue the operation.

## Timing

- Cycle 0: start=1 is sampled in IDLE.
- Cycles 1..WIDTH: RUN.
  - shift_en=1.
  - result_bit is valid combinationally from a_bit/b_bit and the carry register. The downstream register consumes it at the edge ending that cycle.
- Cycle WIDTH+1: DONE.
  - done=1, busy=1, shift_en=0.
  - Flags are already valid.
- Cycle WIDTH+2: IDLE. The earliest next start is accepted here, giving a back-to-back throughput of one operation per WIDTH+2 cycles.
- Operand bit k (k=0 is the LSB) must be present on a_bit/b_bit in RUN cycle k+1.
- shift_en, busy and done are registered-state decodes with no combinational path from start.
- result_bit has a combinational path from a_bit, b_bit and the op/carry registers only.

## Test plan

- Reset mid-RUN: assert rstn=0 during cycle 3 of an ADD. Required: all outputs 0 immediately, state IDLE, and the next start runs a full WIDTH cycles.
- ADD, WIDTH=8, 0x7F+0x01: result stream LSB-first equals 0x80; flags c=0, z=0, n=1, v=1; done pulses on cycle 9.
- SUB 0x05−0x05: result 0x00; flags z=1, c=1, n=0, v=0. SUB 0x00−0x01: result 0xFF; flags c=0, n=1.
- CMP 0x10 vs 0x20: result_we=0 for all 8 cycles while shift_en=1 for all 8; flags c=0, n=1, z=0.
- ADC 0xFF+0x00 with carry_in=1: result 0x00, c=1, z=1. Then a start held high through busy: only one operation runs; a second start in the cycle after DONE is accepted.
- Logic ops AND/OR/XOR/PASSB on A=0xA5, B=0x3C: results 0x24, 0xBD, 0x99, 0x3C; flag_c=0 and flag_v=0 for each.
